uart_boot_loader: RTL

- Sits upstream of the CPU/ROM pair and programs memory over the serial link, so directed instruction programs can be loaded without rebuilding the bitstream.
- Consumes the byte stream from the UART receiver and parses framed commands.
- Issues single-cycle write strobes to the program memory port.
- Holds the CPU in reset until a RUN command arrives.

---
 rtl/uart_boot_loader_pkg.sv | 26 ++
 rtl/uart_boot_loader_if.sv | 42 ++++
 rtl/uart_boot_loader_timeout.sv | 24 ++
 rtl/uart_boot_loader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the serial boot loader: frame constants,
// parser state type and the frame-length helper.
package uart_boot_loader_pkg;

  localparam logic [7:0] LOADER_SYNC      = 8'hA5;
  localparam logic [7:0] LOADER_CMD_WRITE = 8'h01;
  localparam logic [7:0] LOADER_CMD_RUN   = 8'h02;
  localparam logic [7:0] LOADER_ACK       = 8'h06;
  localparam logic [7:0] LOADER_NAK       = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_AHI,
    S_ALO,
    S_LEN,
    S_DATA,
    S_CHK
  } loader_state_t;

  // A LEN byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] frame_len(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Boot loader bus bundle: UART receive stream, program-memory write port,
// CPU control/status and, with UART_BOOT_LOADER_ACK_EN, the response channel.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            rx_data_i;
  logic                  rx_valid_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  cpu_hold_o;
  logic                  load_done_o;
  logic                  load_error_o;
`ifdef UART_BOOT_LOADER_ACK_EN
  logic [7:0]            tx_data_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output mem_we_o, mem_addr_o, mem_wdata_o,
           cpu_hold_o, load_done_o, load_error_o, tx_data_o, tx_valid_o
  );
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
           cpu_hold_o, load_done_o, load_error_o, tx_data_o, tx_valid_o
  );
`else
  modport master (
    input  rx_data_i, rx_valid_i,
    output mem_we_o, mem_addr_o, mem_wdata_o,
           cpu_hold_o, load_done_o, load_error_o
  );
  modport slave (
    output rx_data_i, rx_valid_i,
    input  mem_we_o, mem_addr_o, mem_wdata_o,
           cpu_hold_o, load_done_o, load_error_o
  );
`endif
endinterface

// File: rtl/uart_boot_loader_timeout.sv
// Reloadable inter-byte down-counter; expired asserts once CYCLES enabled
// clocks have passed without a reload.
module loader_timeout_counter #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expired
);
  localparam int unsigned W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] count;

  // Reload on every byte (and while idle); count down otherwise, saturating at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= W'(CYCLES);
    else if (reload)                   count <= W'(CYCLES);
    else if (enable && count != '0)    count <= count - 1'b1;
  end

  assign expired = enable && (count == '0);
endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: parses SYNC-framed WRITE/RUN commands from the UART
// byte stream, writes program memory and holds the CPU until RUN.
// Optional response channel: define UART_BOOT_LOADER_ACK_EN.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          DATA_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  uart_boot_loader_if.master bus
);
  loader_state_t         state, state_next;
  logic [7:0]            b;
  logic                  v;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            remain;
  logic [7:0]            csum;
  logic                  expired;

  logic                  mem_we, cpu_hold, load_done, load_error;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic take_sync, cap_hi, cap_lo, cap_len, do_write;
  logic cmd_write, cmd_run, frame_good, frame_bad;

  assign b = bus.rx_data_i;
  assign v = bus.rx_valid_i;

  loader_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .reload  (v || state == S_IDLE),
    .enable  (state != S_IDLE),
    .expired (expired)
  );

  // Parser state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and per-byte control strobes; a byte arriving on the
  // expiry cycle wins over the timeout.
  always_comb begin
    state_next = state;
    take_sync  = 1'b0;
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    cap_len    = 1'b0;
    do_write   = 1'b0;
    cmd_write  = 1'b0;
    cmd_run    = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (expired && !v) begin
      state_next = S_IDLE;
      frame_bad  = 1'b1;
    end else if (v) begin
      unique case (state)
        S_IDLE: if (b == SYNC_BYTE) begin
          state_next = S_CMD;
          take_sync  = 1'b1;
        end
        S_CMD: begin
          state_next = S_IDLE;
          if (b == LOADER_CMD_WRITE) begin
            state_next = S_AHI;
            cmd_write  = 1'b1;
          end else if (b == LOADER_CMD_RUN) begin
            cmd_run    = 1'b1;
            frame_good = 1'b1;
          end else begin
            frame_bad  = 1'b1;
          end
        end
        S_AHI: begin state_next = S_ALO;  cap_hi  = 1'b1; end
        S_ALO: begin state_next = S_LEN;  cap_lo  = 1'b1; end
        S_LEN: begin state_next = S_DATA; cap_len = 1'b1; end
        S_DATA: begin
          do_write = 1'b1;
          if (remain == 9'd1) state_next = S_CHK;
        end
        S_CHK: begin
          state_next = S_IDLE;
          if (8'(csum + b) == 8'h00) frame_good = 1'b1;
          else                       frame_bad  = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Field capture, checksum, memory write port and CPU control/status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hi    <= '0;
      addr       <= '0;
      remain     <= '0;
      csum       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we    <= do_write;
      load_done <= cmd_run;
      if (take_sync) csum <= '0;
      else if (cap_hi || cap_lo || cap_len || do_write) csum <= csum + b;
      if (cap_hi)  addr_hi <= b;
      if (cap_lo)  addr    <= ADDR_WIDTH'({addr_hi, b});
      if (cap_len) remain  <= frame_len(b);
      if (do_write) begin
        mem_addr  <= addr;
        mem_wdata <= DATA_WIDTH'(b);
        addr      <= addr + 1'b1;
        remain    <= remain - 1'b1;
      end
      if (cmd_write) cpu_hold <= 1'b1;
      if (cmd_run)   cpu_hold <= 1'b0;
      if (take_sync) load_error <= 1'b0;
      if (frame_bad) load_error <= 1'b1;
    end
  end

  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.cpu_hold_o   = cpu_hold;
  assign bus.load_done_o  = load_done;
  assign bus.load_error_o = load_error;

`ifdef UART_BOOT_LOADER_ACK_EN
  logic [7:0] tx_data;
  logic       tx_valid;

  // One-deep response slot; a newer frame result overwrites an undrained one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (frame_good || frame_bad) begin
      tx_data  <= frame_good ? LOADER_ACK : LOADER_NAK;
      tx_valid <= 1'b1;
    end else if (tx_valid && bus.tx_ready_i) begin
      tx_valid <= 1'b0;
    end
  end

  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
`endif
endmodule
